// File: rtl/uart_rx_checked_if.sv
// Byte-side interface of the UART receiver: received data, its valid/ack
// handshake, one-cycle error pulses and the busy indication.
interface uart_rx_checked_if;
  // Handshake: rx_valid is a level that rises when a good byte lands in dataout
  // and holds until the consumer raises rx_ack for a cycle while rx_valid is 1.
  // rx_ack while rx_valid is 0 does nothing. A new good byte arriving in the
  // same cycle as rx_ack wins: rx_valid stays 1 and no overrun is flagged.
  logic       rx_ack;
  logic [7:0] dataout;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  modport master (
    input  rx_ack,
    output dataout,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun_err,
    output busy
  );

  modport slave (
    output rx_ack,
    input  dataout,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  overrun_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_checked.sv
// Oversampling UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Samples mid-bit, checks parity and stop, and hands bytes over via rx_bus.
module uart_rx_checked #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_in,
  uart_rx_checked_if.master         rx_bus,
  output logic [2:0]                state_dbg
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_mis_q, par_mis_d;
  logic [7:0]    dataout_q, dataout_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  // Synchronizer flops reset high so the idle line is not mistaken for a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_mis_q <= 1'b0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_mis_q <= par_mis_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_mis_d = par_mis_q;
    dataout_d = dataout_q;
    valid_d   = valid_q & ~rx_bus.rx_ack;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is high again at its midpoint was only a glitch.
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      PARITY: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d     = '0;
          par_mis_d = rx_s ^ (^shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (!par_mis_q) begin
              dataout_d = shift_q;
              valid_d   = 1'b1;
              ovr_d     = valid_q & ~rx_bus.rx_ack;
            end else begin
              perr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            perr_d  = par_mis_q;
            state_d = BRK_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // A line held low after a bad stop bit is a break, not a stream of frames.
      BRK_WAIT: begin
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_bus.dataout     = dataout_q;
  assign rx_bus.rx_valid    = valid_q;
  assign rx_bus.parity_err  = perr_q;
  assign rx_bus.frame_err   = ferr_q;
  assign rx_bus.overrun_err = ovr_q;
  assign rx_bus.busy        = (state_q != IDLE) && (state_q != BRK_WAIT);
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_uart_rx_checked.sv
// Directed bench for uart_rx_checked: one task per scenario, inline checks,
// a negedge monitor counting error pulses and the cycle of each rx_valid rise.
module tb_uart_rx_checked;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_perr = 0, n_ferr = 0, n_ovr = 0;
  int last_perr = -1, last_ferr = -1, last_ovr = -1, last_rise = -1;
  logic prev_valid = 1'b0;

  uart_rx_checked_if bus ();

  uart_rx_checked #(.CLKS_PER_BIT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_bus    (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters count high cycles, so a stretched pulse shows up as extra counts.
  always @(negedge clk) begin
    prev_valid <= bus.rx_valid;
    if (bus.rx_valid === 1'b1 && prev_valid !== 1'b1) last_rise <= cyc;
    if (bus.parity_err === 1'b1) begin n_perr <= n_perr + 1; last_perr <= cyc; end
    if (bus.frame_err === 1'b1) begin n_ferr <= n_ferr + 1; last_ferr <= cyc; end
    if (bus.overrun_err === 1'b1) begin n_ovr <= n_ovr + 1; last_ovr <= cyc; end
  end

  // ---------------- driver tasks ----------------
  // Call at a negedge; leaves the line at the stop-bit value on return.
  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop_v,
                            output int t0);
    t0 = cyc;
    rx_in = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (16) @(negedge clk);
    end
    rx_in = (^d) ^ flip;
    repeat (16) @(negedge clk);
    rx_in = stop_v;
    repeat (16) @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1; bus.rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.dataout !== 8'h00) begin bad++; $display("FAIL reset_dataout got=%h want=00", bus.dataout); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.rx_valid); end
    total++; if ({bus.parity_err, bus.frame_err, bus.overrun_err} !== 3'b000) begin bad++; $display("FAIL reset_errs got=%b want=000", {bus.parity_err, bus.frame_err, bus.overrun_err}); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_parity();
    int t0, p0, f0, o0;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h01, 1'b1, 1'b1, t0);
    repeat (2) @(negedge clk);
    #1;
    total++; if (n_perr !== p0 + 1) begin bad++; $display("FAIL parity_count got=%0d want=%0d", n_perr - p0, 1); end
    total++; if (last_perr !== t0 + 171) begin bad++; $display("FAIL parity_time got=%0d want=%0d", last_perr - t0, 171); end
    total++; if (n_ferr !== f0 || n_ovr !== o0) begin bad++; $display("FAIL parity_other_flags got=%0d/%0d want=0/0", n_ferr - f0, n_ovr - o0); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL parity_valid got=%b want=0", bus.rx_valid); end
    total++; if (bus.dataout !== 8'h00) begin bad++; $display("FAIL parity_dataout got=%h want=00", bus.dataout); end
  endtask

  task automatic test_good_frame();
    int t0, p0, f0, o0;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'hA5, 1'b0, 1'b1, t0);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (last_rise !== t0 + 171) begin bad++; $display("FAIL good_latency got=%0d want=%0d", last_rise - t0, 171); end
    total++; if (bus.dataout !== 8'hA5) begin bad++; $display("FAIL good_dataout got=%h want=a5", bus.dataout); end
    total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL good_valid got=%b want=1", bus.rx_valid); end
    total++; if (n_perr !== p0 || n_ferr !== f0 || n_ovr !== o0) begin bad++; $display("FAIL good_flags got=%0d/%0d/%0d want=0/0/0", n_perr - p0, n_ferr - f0, n_ovr - o0); end
    do_ack();
    #1;
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL good_ack_clear got=%b want=0", bus.rx_valid); end
    total++; if (bus.dataout !== 8'hA5) begin bad++; $display("FAIL good_ack_dataout got=%h want=a5", bus.dataout); end
  endtask

  task automatic test_glitch();
    int p0, f0, o0;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL glitch_start_busy got=%b want=1", bus.busy); end
    repeat (20) @(negedge clk);
    #1;
    total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL glitch_idle got=%0d want=0", state_dbg); end
    total++; if (n_perr !== p0 || n_ferr !== f0 || n_ovr !== o0) begin bad++; $display("FAIL glitch_flags got=%0d/%0d/%0d want=0/0/0", n_perr - p0, n_ferr - f0, n_ovr - o0); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b want=0", bus.rx_valid); end
  endtask

  task automatic test_break();
    int t0, p0, f0, o0;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    repeat (2) @(negedge clk);
    #1;
    total++; if (n_ferr !== f0 + 1) begin bad++; $display("FAIL break_ferr_count got=%0d want=1", n_ferr - f0); end
    total++; if (last_ferr !== t0 + 171) begin bad++; $display("FAIL break_ferr_time got=%0d want=171", last_ferr - t0); end
    total++; if (n_perr !== p0) begin bad++; $display("FAIL break_perr got=%0d want=0", n_perr - p0); end
    total++; if (bus.dataout !== 8'hA5) begin bad++; $display("FAIL break_dataout got=%h want=a5", bus.dataout); end
    repeat (40 * 16) @(negedge clk);
    #1;
    total++; if (n_ferr !== f0 + 1 || n_perr !== p0 || n_ovr !== o0) begin bad++; $display("FAIL break_hold_flags got=%0d/%0d/%0d want=0/1/0", n_perr - p0, n_ferr - f0, n_ovr - o0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL break_busy got=%b want=0", bus.busy); end
    total++; if (state_dbg !== 3'd5) begin bad++; $display("FAIL break_state got=%0d want=5", state_dbg); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL break_valid got=%b want=0", bus.rx_valid); end
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL break_release got=%0d want=0", state_dbg); end
    @(negedge clk);
    send_frame(8'h55, 1'b0, 1'b1, t0);
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.dataout !== 8'h55 || bus.rx_valid !== 1'b1) begin bad++; $display("FAIL break_after got=%h/%b want=55/1", bus.dataout, bus.rx_valid); end
  endtask

  // Leaves 0x55 unacknowledged beforehand so the reset visibly clears it.
  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int t0, p0, f0, o0;
    d = 8'h5A;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = d[i];
      repeat (16) @(negedge clk);
    end
    rx_in = d[4];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    #1;
    total++; if (bus.dataout !== 8'h00 || bus.rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_data got=%h/%b want=00/0", bus.dataout, bus.rx_valid); end
    total++; if (bus.busy !== 1'b0 || state_dbg !== 3'd0) begin bad++; $display("FAIL rstmid_state got=%b/%0d want=0/0", bus.busy, state_dbg); end
    total++; if ({bus.parity_err, bus.frame_err, bus.overrun_err} !== 3'b000) begin bad++; $display("FAIL rstmid_errs got=%b want=000", {bus.parity_err, bus.frame_err, bus.overrun_err}); end
    rst = 1'b0;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    repeat (200) @(negedge clk);
    #1;
    total++; if (n_perr !== p0 || n_ferr !== f0 || n_ovr !== o0 || bus.rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=%0d/%0d/%0d/%b want=0/0/0/0", n_perr - p0, n_ferr - f0, n_ovr - o0, bus.rx_valid); end
    @(negedge clk);
    send_frame(8'h7E, 1'b0, 1'b1, t0);
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.dataout !== 8'h7E || bus.rx_valid !== 1'b1) begin bad++; $display("FAIL rstmid_next got=%h/%b want=7e/1", bus.dataout, bus.rx_valid); end
    total++; if (last_rise !== t0 + 171) begin bad++; $display("FAIL rstmid_latency got=%0d want=171", last_rise - t0); end
    do_ack();
  endtask

  task automatic test_overrun();
    int t0, t1, o0;
    o0 = n_ovr;
    @(negedge clk);
    send_frame(8'h11, 1'b0, 1'b1, t0);
    send_frame(8'h22, 1'b0, 1'b1, t1);
    repeat (2) @(negedge clk);
    #1;
    total++; if (n_ovr !== o0 + 1) begin bad++; $display("FAIL overrun_count got=%0d want=1", n_ovr - o0); end
    total++; if (last_ovr !== t1 + 171) begin bad++; $display("FAIL overrun_time got=%0d want=171", last_ovr - t1); end
    total++; if (bus.dataout !== 8'h22 || bus.rx_valid !== 1'b1) begin bad++; $display("FAIL overrun_data got=%h/%b want=22/1", bus.dataout, bus.rx_valid); end
    total++; if (last_rise !== t0 + 171) begin bad++; $display("FAIL overrun_first_rise got=%0d want=171", last_rise - t0); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int t0, t1, t1b, o0;
    o0 = n_ovr;
    @(negedge clk);
    send_frame(8'h11, 1'b0, 1'b1, t0);
    t1b = cyc;
    fork
      send_frame(8'h22, 1'b0, 1'b1, t1);
      begin
        while (cyc != t1b + 170) @(negedge clk);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    #1;
    total++; if (n_ovr !== o0) begin bad++; $display("FAIL race_overrun got=%0d want=0", n_ovr - o0); end
    total++; if (bus.dataout !== 8'h22 || bus.rx_valid !== 1'b1) begin bad++; $display("FAIL race_data got=%h/%b want=22/1", bus.dataout, bus.rx_valid); end
    total++; if (last_rise !== t0 + 171) begin bad++; $display("FAIL race_valid_held got=%0d want=171", last_rise - t0); end
    do_ack();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_parity();
    test_good_frame();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_overrun();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_checked.md
Name: uart_rx_checked

Overview:
- Single-clock UART receiver for the serial frame our UART transmitters produce.
- Frame format: idle high, start bit 0, 8 data bits LSB first, parity bit, stop bit 1.
- Parity bit is 1 when the data byte has an odd number of ones (even parity overall).
- Oversamples the line, samples each bit at its midpoint, checks parity and stop bit, and hands received bytes to the core through a valid/ack handshake with error flags.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4. HALF = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  reset; synchronous, active-high.
- rx_in  input  1  asynchronous serial line, idle high.
- rx_ack  input  1  consumer acknowledges the byte held in dataout; clears rx_valid.
- dataout  output  8  last byte received without error.
- rx_valid  output  1  level; 1 while dataout holds an unacknowledged byte.
- parity_err  output  1  one-cycle pulse: the frame's parity bit mismatched.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun_err  output  1  one-cycle pulse: a good byte overwrote an unacknowledged one.
- busy  output  1  1 in every state except IDLE and BRK_WAIT.

Behaviour:
- Reset: dataout=0, rx_valid=0, all error pulses=0, busy=0, state=IDLE, counters=0.
  - Both synchronizer flops reset to 1 so no false start follows reset.
  - Reset mid-frame abandons the frame; no flags fire.
- Input: rx_in passes through a 2-flop synchronizer, giving rx_s. All decisions use rx_s only.
- IDLE: when rx_s==0, go to START with bit counter cnt=0.
- START: cnt increments each cycle. At cnt==HALF-1, sample rx_s:
  - 0: go to DATA with cnt=0, bit index=0.
  - 1: glitch; return to IDLE with no flags.
- DATA: at each cnt==CLKS_PER_BIT-1, sample rx_s into shift register bit[index] (LSB first) and reset cnt.
  - After index 7 is sampled, go to PARITY.
- PARITY: sample at cnt==CLKS_PER_BIT-1. Store mismatch = sampled bit XOR (XOR-reduce of data). Go to STOP.
- STOP: sample at cnt==CLKS_PER_BIT-1. Outcomes are registered at that edge:
  - stop==1 and no parity mismatch: dataout<=shift register, rx_valid<=1. If rx_valid was 1 and rx_ack is 0 this cycle, pulse overrun_err. Go to IDLE.
  - stop==1 and parity mismatch: pulse parity_err; dataout and rx_valid unchanged. Go to IDLE.
  - stop==0: pulse frame_err; also pulse parity_err if mismatched. dataout unchanged. Go to BRK_WAIT.
- BRK_WAIT: stay until rx_s==1, then go to IDLE. This keeps a held-low line (break) from being read as repeated frames.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid next cycle.
  - rx_ack with rx_valid=0 is ignored.
  - rx_ack in the same cycle as a good-frame completion: the new byte wins, rx_valid stays 1, no overrun.
- Latency: let T be the edge that first registers rx_in=0.
  - Start bit is sampled at edge T+2+HALF.
  - Data bit i is sampled at T+2+HALF+(i+1)·CLKS_PER_BIT.
  - Stop bit is sampled, and outputs update, at T+2+HALF+10·CLKS_PER_BIT. With defaults this is T+170.
- Back-to-back frames: the state returns to IDLE at mid-stop-bit, so a start edge immediately after the stop bit is accepted. No idle gap is required.
- Counter width: ceil(log2(CLKS_PER_BIT)). cnt never wraps past CLKS_PER_BIT-1.

Test Plan:
- Good frame: send 0xA5 (four ones, parity bit 0, stop 1) after reset → dataout=0xA5 and rx_valid=1 at T+170; no error pulses. rx_ack then clears rx_valid next cycle.
- Parity error: send 0x01 with parity bit 0 → parity_err pulses for one cycle; rx_valid stays 0; dataout stays 0x00.
- Framing and break:
  - Send 0x3C with stop bit 0 → frame_err pulses; dataout unchanged.
  - Then hold the line low for 40 bit times → no further flags; busy=0.
  - Release the line, then send 0x55 → dataout=0x55.
- Glitch and reset:
  - A 3-cycle low pulse on an idle line → returns to IDLE; no flags; rx_valid=0.
  - Assert rst during data bit 4 of a frame → all outputs 0 next cycle.
  - A following clean 0x7E is received correctly.
- Overrun and ack race:
  - Send 0x11 then 0x22 back-to-back without ack → overrun_err pulses at the second stop sample; dataout=0x22.
  - Repeat with rx_ack asserted exactly at the second stop-sample edge → no overrun; rx_valid=1; dataout=0x22.
